// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the debug UART transmit arbiter: default sizing and FSM state encodings.
package uart_tx_arbiter_pkg;

  localparam int ARB_NUM_REQ       = 4;
  localparam int ARB_REQ_IDX_WIDTH = 2;
  localparam int ARB_UART_LEN      = 8;
  localparam int ARB_TIMEOUT       = 1024;
  localparam int ARB_TIMER_WIDTH   = 10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between the packet sources, the arbiter and the TX serializer.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int UART_LEN = ARB_UART_LEN
);

  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*UART_LEN-1:0] req_byte;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        tx_start;
  logic [UART_LEN-1:0]         tx_byte;
  logic                        tx_done;

  // slave is the arbiter's view; master is the requester/serializer side
  modport slave (
    input  req_valid, req_byte, req_last, tx_done,
    output req_ready, tx_start, tx_byte
  );

  modport master (
    output req_valid, req_byte, req_last, tx_done,
    input  req_ready, tx_start, tx_byte
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping at NUM_REQ-1.
module uart_tx_arbiter_rr_priority_picker #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  // Walk the candidates explicitly so non-power-of-two NUM_REQ wraps correctly
  always_comb begin
    logic [IDX_WIDTH-1:0] cand;
    found = 1'b0;
    idx   = '0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
      cand = (int'(cand) == NUM_REQ - 1) ? '0 : cand + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the debug UART byte transmitter between packet sources; round-robin grant locked per packet,
// with stall timeout and flush.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = ARB_NUM_REQ,
  parameter int REQ_IDX_WIDTH = ARB_REQ_IDX_WIDTH,
  parameter int UART_LEN      = ARB_UART_LEN,
  parameter int TIMEOUT       = ARB_TIMEOUT,
  parameter int TIMER_WIDTH   = ARB_TIMER_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.slave         bus,
  input  logic                     flush,
  output logic                     grant_valid,
  output logic [REQ_IDX_WIDTH-1:0] grant_id,
  output logic                     err_timeout
);

  arb_state_e               state, state_nxt;
  logic [REQ_IDX_WIDTH-1:0] rr_ptr, rr_ptr_nxt, grant_id_nxt, grant_inc, pick_idx;
  logic                     pick_found;
  logic [TIMER_WIDTH-1:0]   timer, timer_nxt;
  logic                     tx_start_r, tx_start_nxt;
  logic [UART_LEN-1:0]      tx_byte_r, tx_byte_nxt, sel_byte;
  logic                     last_r, last_nxt, sel_valid, sel_last;
  logic                     flush_pend, flush_pend_nxt;
  logic                     grant_valid_nxt, err_timeout_nxt;
  logic [NUM_REQ-1:0]       req_ready_c;

  uart_tx_arbiter_rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_IDX_WIDTH)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign sel_valid = bus.req_valid[grant_id];
  assign sel_last  = bus.req_last[grant_id];
  assign sel_byte  = bus.req_byte[int'(grant_id)*UART_LEN +: UART_LEN];
  assign grant_inc = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

  assign bus.req_ready = req_ready_c;
  assign bus.tx_start  = tx_start_r;
  assign bus.tx_byte   = tx_byte_r;

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_id_nxt    = grant_id;
    grant_valid_nxt = grant_valid;
    timer_nxt       = timer;
    tx_start_nxt    = 1'b0;
    tx_byte_nxt     = tx_byte_r;
    last_nxt        = last_r;
    flush_pend_nxt  = flush_pend;
    err_timeout_nxt = 1'b0;
    req_ready_c     = '0;
    case (state)
      ARB_IDLE: begin
        if (!flush && pick_found) begin
          grant_id_nxt    = pick_idx;
          grant_valid_nxt = 1'b1;
          timer_nxt       = '0;
          state_nxt       = ARB_HOLD;
        end
      end
      ARB_HOLD: begin
        // Flush wins over a byte offered in the same cycle
        if (flush) begin
          rr_ptr_nxt      = grant_inc;
          grant_valid_nxt = 1'b0;
          flush_pend_nxt  = 1'b0;
          state_nxt       = ARB_IDLE;
        end else if (sel_valid) begin
          req_ready_c[grant_id] = 1'b1;
          tx_byte_nxt           = sel_byte;
          last_nxt              = sel_last;
          tx_start_nxt          = 1'b1;
          state_nxt             = ARB_WAIT;
        end else if (timer == TIMER_WIDTH'(TIMEOUT - 1)) begin
          err_timeout_nxt = 1'b1;
          rr_ptr_nxt      = grant_inc;
          grant_valid_nxt = 1'b0;
          state_nxt       = ARB_IDLE;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      ARB_WAIT: begin
        if (flush) flush_pend_nxt = 1'b1;
        if (bus.tx_done) begin
          if (last_r || flush_pend || flush) begin
            rr_ptr_nxt      = grant_inc;
            grant_valid_nxt = 1'b0;
            flush_pend_nxt  = 1'b0;
            state_nxt       = ARB_IDLE;
          end else begin
            timer_nxt = '0;
            state_nxt = ARB_HOLD;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      timer       <= '0;
      tx_start_r  <= 1'b0;
      tx_byte_r   <= '0;
      last_r      <= 1'b0;
      flush_pend  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant_id    <= grant_id_nxt;
      grant_valid <= grant_valid_nxt;
      timer       <= timer_nxt;
      tx_start_r  <= tx_start_nxt;
      tx_byte_r   <= tx_byte_nxt;
      last_r      <= last_nxt;
      flush_pend  <= flush_pend_nxt;
      err_timeout <= err_timeout_nxt;
    end
  end

endmodule
